// File: rtl/test_seq_ctrl.sv
// test_seq_ctrl: link self-test sequencer.
// Arms the RX checker, then requests a programmed number of frames from the TX
// test generator with a configurable idle gap between frames. It counts sent and
// received frames, latches checker errors and flags frames still missing when
// the flush timer runs out.
`default_nettype none

module test_seq_ctrl #(
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 32,
    parameter int GAP_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [LEN_W-1:0] cfg_frame_len,
    input  logic [CNT_W-1:0] cfg_frame_num,
    input  logic [GAP_W-1:0] cfg_gap,
    output logic             tx_start,
    output logic [LEN_W-1:0] tx_len,
    input  logic             tx_done,
    input  logic             mac_rx_valid,
    input  logic             mac_rx_eof,
    input  logic             chk_err,
    output logic             chk_start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             timeout,
    output logic [CNT_W-1:0] tx_cnt,
    output logic [CNT_W-1:0] rx_cnt
);

    // The flush timer runs 0 .. TIMEOUT-1.
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_SEND    = 3'd2;
    localparam logic [2:0] S_WAIT_TX = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_FLUSH   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic             run_q, run_d;
    logic             edge_q, edge_d;
    logic             tx_done_q, tx_done_d;
    logic [LEN_W-1:0] cfg_len_q, cfg_len_d;
    logic [CNT_W-1:0] cfg_num_q, cfg_num_d;
    logic [GAP_W-1:0] cfg_gap_q, cfg_gap_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;
    logic             arm_cnt_q, arm_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Decoded conditions shared by the state machine and the datapath.
    logic             start_test;
    logic             rx_window;
    logic             err_window;
    logic             last_frame;
    logic             tx_event;
    logic             rx_event;
    logic [CNT_W:0]   tx_cnt_inc;

    // Derive the start/window/last-frame conditions from the current state.
    always_comb begin
        start_test = edge_q && ((state_q == S_IDLE) || (state_q == S_DONE));
        rx_window  = (state_q == S_ARM)     || (state_q == S_SEND) ||
                     (state_q == S_WAIT_TX) || (state_q == S_GAP)  ||
                     (state_q == S_FLUSH);
        // The checker clears its own flags while armed, so ARM is excluded.
        err_window = (state_q == S_SEND) || (state_q == S_WAIT_TX) ||
                     (state_q == S_GAP)  || (state_q == S_FLUSH);
        tx_event   = (state_q == S_WAIT_TX) && tx_done_q;
        rx_event   = rx_window && mac_rx_valid && mac_rx_eof;
        tx_cnt_inc = {1'b0, tx_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        last_frame = (cfg_num_q != '0) && (tx_cnt_inc == {1'b0, cfg_num_q});
    end

    // Edge detection on run and capture of tx_done while a frame is outstanding.
    // Registering both gives the fixed 4-cycle start latency and the 2-cycle
    // back-to-back turnaround.
    always_comb begin
        run_d     = run;
        edge_d    = run && !run_q;
        tx_done_d = tx_done && (state_q == S_WAIT_TX) && !tx_done_q;
    end

    // Test sequencing state machine.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_test) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (arm_cnt_q) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_done_q) begin
                    if (!run || last_frame) begin
                        state_d = S_FLUSH;
                    end else if (cfg_gap_q == '0) begin
                        state_d = S_SEND;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (!run) begin
                    state_d = S_FLUSH;
                end else if (gap_cnt_q == cfg_gap_q - GAP_W'(1)) begin
                    state_d = S_SEND;
                end
            end
            S_FLUSH: begin
                if (rx_cnt_q == tx_cnt_q) begin
                    state_d = S_DONE;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start_test) begin
                    state_d = S_ARM;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Per-state cycle counters; each restarts from zero on entry to its state.
    always_comb begin
        arm_cnt_d = (state_q == S_ARM)   ? !arm_cnt_q : 1'b0;
        gap_cnt_d = (state_q == S_GAP)   ? gap_cnt_q + GAP_W'(1) : '0;
        tmr_d     = (state_q == S_FLUSH) ? tmr_q + TMR_W'(1)     : '0;
    end

    // Configuration is captured only when a test starts and held for its duration.
    always_comb begin
        cfg_len_d = cfg_len_q;
        cfg_num_d = cfg_num_q;
        cfg_gap_d = cfg_gap_q;
        if (start_test) begin
            cfg_len_d = cfg_frame_len;
            cfg_num_d = cfg_frame_num;
            cfg_gap_d = cfg_gap;
        end
    end

    // Saturating frame counters, cleared at test start.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if (start_test) begin
            tx_cnt_d = '0;
            rx_cnt_d = '0;
        end else begin
            if (tx_event && (tx_cnt_q != '1)) begin
                tx_cnt_d = tx_cnt_inc[CNT_W-1:0];
            end
            if (rx_event && (rx_cnt_q != '1)) begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
        end
    end

    // Sticky status flags, cleared at test start.
    always_comb begin
        err_d     = err_q;
        timeout_d = timeout_q;
        if (start_test) begin
            err_d     = 1'b0;
            timeout_d = 1'b0;
        end else begin
            if (err_window && chk_err) begin
                err_d = 1'b1;
            end
            if ((state_q == S_FLUSH) && (rx_cnt_q != tx_cnt_q) && (tmr_q == TMR_LAST)) begin
                timeout_d = 1'b1;
            end
        end
    end

    // State and datapath registers. run_q resets high so that a run level held
    // across reset is not mistaken for a new start request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b1;
            edge_q    <= 1'b0;
            tx_done_q <= 1'b0;
            cfg_len_q <= '0;
            cfg_num_q <= '0;
            cfg_gap_q <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            arm_cnt_q <= 1'b0;
            gap_cnt_q <= '0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            edge_q    <= edge_d;
            tx_done_q <= tx_done_d;
            cfg_len_q <= cfg_len_d;
            cfg_num_q <= cfg_num_d;
            cfg_gap_q <= cfg_gap_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            arm_cnt_q <= arm_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            tmr_q     <= tmr_d;
        end
    end

    // Control outputs decode the state directly so reset clears them immediately.
    always_comb begin
        tx_start  = (state_q == S_SEND);
        chk_start = rx_window;
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
        tx_len    = cfg_len_q;
        err       = err_q;
        timeout   = timeout_q;
        tx_cnt    = tx_cnt_q;
        rx_cnt    = rx_cnt_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_test_seq_ctrl.sv
// Bench for test_seq_ctrl: ideal TX/RX models plus a tx_start timing scoreboard.
`timescale 1ns/1ps

module tb_test_seq_ctrl;

    localparam int LEN_W  = 16;
    localparam int CNT_W  = 32;
    localparam int GAP_W  = 16;
    localparam int TO     = 300;
    localparam int TX_LAT = 6;

    logic             clk;
    logic             rst;
    logic             run;
    logic [LEN_W-1:0] cfg_frame_len;
    logic [CNT_W-1:0] cfg_frame_num;
    logic [GAP_W-1:0] cfg_gap;
    logic             tx_start;
    logic [LEN_W-1:0] tx_len;
    logic             tx_done;
    logic             mac_rx_valid;
    logic             mac_rx_eof;
    logic             chk_err;
    logic             chk_start;
    logic             busy;
    logic             done;
    logic             err;
    logic             timeout;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rx_cnt;

    test_seq_ctrl #(
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W),
        .GAP_W   (GAP_W),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .cfg_frame_len (cfg_frame_len),
        .cfg_frame_num (cfg_frame_num),
        .cfg_gap       (cfg_gap),
        .tx_start      (tx_start),
        .tx_len        (tx_len),
        .tx_done       (tx_done),
        .mac_rx_valid  (mac_rx_valid),
        .mac_rx_eof    (mac_rx_eof),
        .chk_err       (chk_err),
        .chk_start     (chk_start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .timeout       (timeout),
        .tx_cnt        (tx_cnt),
        .rx_cnt        (rx_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected tx_start cycles, pushed when the stimulus that
    // causes them (run edge, tx_done) is driven.
    int exp_start_q[$];
    int rx_q[$];

    int len_exp, num_exp, gap_exp;
    int sent, starts_seen;
    int stop_after, drop_frame, err_frame;
    int txd_at, err_at, eofnv_at, last_txd, done_cyc;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One bench cycle: sample at the falling edge, then drive the TX/RX models.
    task automatic tick();
        int e;
        @(negedge clk);
        tx_done      = 1'b0;
        mac_rx_valid = 1'b0;
        mac_rx_eof   = 1'b0;
        chk_err      = 1'b0;
        if (!rst) begin
            check_val("chk_start_eq_busy", chk_start, busy);
            if (busy) check_val("done_while_busy", done, 0);
            if (tx_start) begin
                starts_seen++;
                if (exp_start_q.size() == 0) begin
                    check_val("tx_start_unexpected", 1, 0);
                end else begin
                    e = exp_start_q.pop_front();
                    check_val("tx_start_cycle", cyc, e);
                end
                check_val("tx_len", tx_len, len_exp);
                txd_at = cyc + TX_LAT;
                if (starts_seen == err_frame) err_at = cyc + 2;
            end
            if (cyc == err_at) chk_err = 1'b1;
            if (cyc == txd_at) begin
                tx_done  = 1'b1;
                sent++;
                last_txd = cyc;
                eofnv_at = cyc + 1;
                if (sent != drop_frame) rx_q.push_back(cyc + 3);
                if (stop_after != 0 && sent == stop_after) run = 1'b0;
                if (run && (num_exp == 0 || sent < num_exp))
                    exp_start_q.push_back(cyc + 2 + gap_exp);
            end
            // eof without valid must not count as a frame
            if (cyc == eofnv_at) mac_rx_eof = 1'b1;
            if (rx_q.size() != 0 && rx_q[0] == cyc) begin
                void'(rx_q.pop_front());
                mac_rx_valid = 1'b1;
                mac_rx_eof   = 1'b1;
            end
        end
    endtask

    task automatic start_run(input int len, input int num, input int gap);
        run = 1'b0;
        tick();
        len_exp = len; num_exp = num; gap_exp = gap;
        cfg_frame_len = LEN_W'(len);
        cfg_frame_num = CNT_W'(num);
        cfg_gap       = GAP_W'(gap);
        sent = 0; starts_seen = 0;
        stop_after = 0; drop_frame = 0; err_frame = 0;
        txd_at = -1; err_at = -1; eofnv_at = -1;
        run = 1'b1;
        exp_start_q.push_back(cyc + 4);
        tick();
        check_val("chk_start_c1", chk_start, 0);
        tick();
        check_val("chk_start_c2", chk_start, 1);
        check_val("start_tx_cnt_clr", tx_cnt, 0);
        check_val("start_rx_cnt_clr", rx_cnt, 0);
        check_val("start_err_clr", err, 0);
        check_val("start_timeout_clr", timeout, 0);
        check_val("start_done_clr", done, 0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (!done) check_val("done_wait_expired", 0, 1);
        done_cyc = cyc;
        check_val("sb_empty", exp_start_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; run = 1'b0;
        cfg_frame_len = '0; cfg_frame_num = '0; cfg_gap = '0;
        tx_done = 1'b0; mac_rx_valid = 1'b0; mac_rx_eof = 1'b0; chk_err = 1'b0;
        len_exp = 0; num_exp = 0; gap_exp = 0; sent = 0; starts_seen = 0;
        stop_after = 0; drop_frame = 0; err_frame = 0;
        txd_at = -1; err_at = -1; eofnv_at = -1; last_txd = 0; done_cyc = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_val("rst_tx_start", tx_start, 0);
        check_val("rst_chk_start", chk_start, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_tx_cnt", tx_cnt, 0);
        check_val("rst_rx_cnt", rx_cnt, 0);
        check_val("rst_tx_len", tx_len, 0);

        // 1: three frames with a gap; cfg changes mid-test must be ignored
        start_run(64, 3, 10);
        tick();
        cfg_frame_len = 16'd7; cfg_frame_num = 32'd1; cfg_gap = 16'd0;
        wait_done(500);
        check_val("t1_tx_cnt", tx_cnt, 3);
        check_val("t1_rx_cnt", rx_cnt, 3);
        check_val("t1_sent", sent, 3);
        check_val("t1_done", done, 1);
        check_val("t1_err", err, 0);
        check_val("t1_timeout", timeout, 0);
        check_val("t1_chk_start", chk_start, 0);
        check_val("t1_busy", busy, 0);

        // 2: continuous, no gap, run dropped with the 5th tx_done
        start_run(32, 0, 0);
        stop_after = 5;
        wait_done(500);
        check_val("t2_tx_cnt", tx_cnt, 5);
        check_val("t2_rx_cnt", rx_cnt, 5);
        check_val("t2_done", done, 1);

        // 3: frame 2 lost on RX -> timeout exactly TO cycles after FLUSH entry
        start_run(16, 4, 2);
        drop_frame = 2;
        wait_done(TO + 500);
        check_val("t3_tx_cnt", tx_cnt, 4);
        check_val("t3_rx_cnt", rx_cnt, 3);
        check_val("t3_timeout", timeout, 1);
        check_val("t3_done", done, 1);
        check_val("t3_done_cycle", done_cyc, last_txd + 2 + TO);

        // 4: checker error during frame 2 is sticky; restart clears it
        start_run(8, 4, 1);
        err_frame = 2;
        wait_done(500);
        check_val("t4_err", err, 1);
        check_val("t4_timeout", timeout, 0);
        check_val("t4_tx_cnt", tx_cnt, 4);
        check_val("t4_rx_cnt", rx_cnt, 4);
        repeat (3) tick();
        check_val("t4_err_sticky", err, 1);
        start_run(8, 1, 0);
        chk_err = 1'b1;    // in ARM: must be ignored
        wait_done(500);
        check_val("t4b_err", err, 0);
        check_val("t4b_tx_cnt", tx_cnt, 1);
        check_val("t4b_rx_cnt", rx_cnt, 1);

        // 5: asynchronous reset while waiting for frame 2
        start_run(8, 3, 0);
        begin
            int n = 0;
            while (starts_seen < 2 && n < 200) begin
                tick();
                n++;
            end
            if (starts_seen < 2) check_val("t5_wait_expired", 0, 1);
        end
        tick();
        tick();
        check_val("t5_pre_tx_cnt", tx_cnt, 1);
        check_val("t5_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_val("t5_rst_busy", busy, 0);
        check_val("t5_rst_chk_start", chk_start, 0);
        check_val("t5_rst_tx_cnt", tx_cnt, 0);
        check_val("t5_rst_rx_cnt", rx_cnt, 0);
        check_val("t5_rst_tx_len", tx_len, 0);
        txd_at = -1; err_at = -1; eofnv_at = -1;
        exp_start_q.delete();
        rx_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();    // run still high: no new start without an edge
        check_val("t5_post_busy", busy, 0);
        check_val("t5_post_tx_cnt", tx_cnt, 0);
        start_run(8, 1, 0);
        wait_done(500);
        check_val("t5_tx_cnt", tx_cnt, 1);
        check_val("t5_rx_cnt", rx_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
